// File: rtl/rv32i_mem_arbiter.sv
// Arbitrates one single-ported synchronous memory between instruction fetch and
// load/store, with a fetch starvation guard and a source-tagged read-return pipeline.
module rv32i_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int READ_LAT   = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    input  logic              mem_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_TOP = SW'(STARVE_MAX);

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_D  = 1'b1
    } src_e;

    logic [SW-1:0]       streak;
    logic [SW-1:0]       streak_nxt;
    logic [READ_LAT-1:0] vld;
    src_e                src_pipe [READ_LAT];
    logic                fetch_wins;
    logic                rd_push;
    src_e                rd_src;

    // Grants are masked during reset so every output reads 0 while rst_n is low.
    always_comb begin
        fetch_wins = if_req && (!d_req || (streak == STREAK_TOP));
        if_gnt     = rst_n && mem_ready && fetch_wins;
        d_gnt      = rst_n && mem_ready && d_req && !fetch_wins;
        mem_en     = if_gnt | d_gnt;
        mem_we     = d_gnt & d_we;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_be     = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
            mem_be   = '1;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_be;
        end
        rd_push = if_gnt | (d_gnt & ~d_we);
        rd_src  = d_gnt ? SRC_D : SRC_IF;
    end

    always_comb begin
        streak_nxt = streak;
        if (!if_req || if_gnt) begin
            streak_nxt = '0;
        end else if (d_gnt && (streak != STREAK_TOP)) begin
            streak_nxt = streak + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
        end else begin
            streak <= streak_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int unsigned i = 0; i < READ_LAT; i++) begin
                src_pipe[i] <= SRC_IF;
            end
        end else begin
            vld[0]      <= rd_push;
            src_pipe[0] <= rd_src;
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                vld[i]      <= vld[i-1];
                src_pipe[i] <= src_pipe[i-1];
            end
        end
    end

    always_comb begin
        if_rvalid = vld[READ_LAT-1] && (src_pipe[READ_LAT-1] == SRC_IF);
        d_rvalid  = vld[READ_LAT-1] && (src_pipe[READ_LAT-1] == SRC_D);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;
        busy      = |vld;
    end

endmodule
